// File: rtl/pc_next_unit.sv
// Next-PC selection, link writeback and return-address stack.
// Resolves execute-stage control flow into the fetch PC.
module pc_next_unit #(
  parameter int          PC_W      = 9,
  parameter int          XLEN      = 32,
  parameter int          RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned TRAP_PC   = 'h1FC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            op_valid,
  input  logic [1:0]      op,
  input  logic            br_taken,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_valid,
  output logic            misalign,
  output logic [PC_W-1:0] ras_top,
  output logic            ras_valid
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] tgt_pc;
  logic [XLEN-1:0] tgt_jr;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] tgt;
  logic            redir;
  logic            mis;
  logic            wr_ok;
  logic            push;
  logic            pop;

  logic [PC_W-1:0] stk [RAS_DEPTH];
  logic [AW-1:0]   ptr;
  logic [AW:0]     cnt;

  // Target arithmetic and redirect/stack decisions.
  always_comb begin
    tgt_pc = ex_pc + imm;
    tgt_jr = (rs1 + imm) & ~XLEN'(1);
    link   = ex_pc + XLEN'(4);
    tgt    = (op == 2'b11) ? tgt_jr : tgt_pc;
    redir  = op_valid && ((op == 2'b00 && br_taken) || op[1]);
    mis    = redir && tgt[1];
    wr_ok  = op_valid && op[1] && !tgt[1];
    push   = wr_ok && is_call;
    pop    = wr_ok && op[0] && is_ret;
  end

  // Fetch PC, flush/misalign pulses and link writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= PC_W'(RESET_PC);
      flush    <= 1'b0;
      misalign <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
    end else begin
      flush    <= redir;
      misalign <= mis;
      if (mis)
        pc <= PC_W'(TRAP_PC);
      else if (redir)
        pc <= tgt[PC_W-1:0];
      else if (!stall)
        pc <= pc + PC_W'(4);
      wb_valid <= 1'b0;
      if (op_valid && op == 2'b01) begin
        wb_valid <= 1'b1;
        wb_data  <= tgt_pc;
      end else if (wr_ok) begin
        wb_valid <= 1'b1;
        wb_data  <= link;
      end
    end
  end

  // Stack pointer and occupancy; full pushes wrap over the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && !pop) begin
      ptr <= ptr + AW'(1);
      if (cnt != FULL)
        cnt <= cnt + (AW+1)'(1);
    end else if (pop && !push && cnt != '0) begin
      ptr <= ptr - AW'(1);
      cnt <= cnt - (AW+1)'(1);
    end
  end

  // Stack storage; a push-with-pop replaces the current top.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      if (pop)
        stk[ptr] <= link[PC_W-1:0];
      else
        stk[ptr + AW'(1)] <= link[PC_W-1:0];
    end
  end

  assign ras_top   = stk[ptr];
  assign ras_valid = (cnt != '0);

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 Parameters: name, default, meaning
- PC_W, 9, fetch PC width in bits
- XLEN, 32, datapath width
- RAS_DEPTH, 4, return-address-stack entries (power of 2, >=2)
- RESET_PC, 0, PC value after reset
- TRAP_PC, 'h1FC, PC loaded on a misaligned target

REQ-002 Ports: name, direction, width, meaning
- clk, in, 1, single clock, rising edge
- reset, in, 1, synchronous, active-high
- stall, in, 1, hold fetch PC
- op_valid, in, 1, execute-stage control word valid
- op, in, 2, 00 seq/branch, 01 auipc, 10 jal, 11 jalr
- br_taken, in, 1, branch condition result (op=00 only)
- is_call, in, 1, jal/jalr is a call (rd=x1/x5)
- is_ret, in, 1, jalr is a return (rs1=x1/x5, rd=x0)
- ex_pc, in, XLEN, PC of executing instruction
- imm, in, XLEN, sign-extended immediate
- rs1, in, XLEN, rs1 operand
- pc, out, PC_W, registered fetch PC
- flush, out, 1, registered one-cycle pulse after a redirect
- wb_data, out, XLEN, registered register-file write data
- wb_valid, out, 1, registered one-cycle write strobe
- misalign, out, 1, registered one-cycle misaligned-target pulse
- ras_top, out, PC_W, predicted return address (top of stack)
- ras_valid, out, 1, stack non-empty

Function
REQ-003 Arithmetic in XLEN bits, modulo 2^XLEN: tgt_pc = ex_pc+imm; tgt_jr = (rs1+imm) with bit0 cleared; link = ex_pc+4.
REQ-004 Redirect is taken when op_valid and (op=00 and br_taken, or op=10, or op=11); target is tgt_pc for op 00/10 and tgt_jr for op 11.
REQ-005 Target bit1 set is a misaligned target: pc <= TRAP_PC, misalign=1 next cycle, no writeback, no stack update.
REQ-006 Next-pc priority: reset > redirect (aligned: target[PC_W-1:0]; misaligned: TRAP_PC) > stall (hold) > pc+4.
REQ-007 A redirect overrides stall in the same cycle.
REQ-008 pc+4 wraps modulo 2^PC_W.
REQ-009 flush = 1 for exactly the cycle after any redirect, including a misaligned one; 0 otherwise.
REQ-010 wb_data/wb_valid update on the edge after op_valid:
- op=01: wb_data = tgt_pc
- op=10/11, aligned: wb_data = link
- otherwise: wb_valid = 0 and wb_data holds its value
REQ-011 op=00 and op=01 never write the stack; br_taken is ignored for op!=00.
REQ-012 Stack push on aligned op 10/11 with is_call: link[PC_W-1:0] goes to the top.
REQ-013 Stack pop on aligned op 11 with is_ret.
REQ-014 Push and pop in the same cycle: the top entry is replaced by the pushed value; count is unchanged.
REQ-015 Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
REQ-016 Pop when empty: no state change; count stays 0.
REQ-017 ras_top shows the current top entry combinationally from registered state; ras_valid = (count != 0).
REQ-018 stall has no effect on wb_data, wb_valid, misalign or the stack.

Reset
REQ-019 On a clk edge with reset=1: pc = RESET_PC; flush, wb_valid and misalign = 0; wb_data = 0; stack count = 0 (ras_valid = 0). All other inputs are ignored that cycle.
REQ-020 Reset asserted mid-redirect or mid-stall takes priority; the cycle after reset deasserts, pc = RESET_PC+4 unless stalled or redirected.

Verification
REQ-021 Reset then 3 free-running cycles -> pc = 0, 4, 8, 12; all pulses 0.
REQ-022 ex_pc=0x40, imm=0x20, op=10, is_call=1, stall=1 -> next cycle: pc = 0x60, flush = 1, wb_valid = 1, wb_data = 0x44, ras_top = 0x44, ras_valid = 1.
REQ-023 rs1=0x101, imm=0x0 (tgt_jr=0x100), op=11, is_ret=1 after REQ-022 -> pc = 0x100, wb_data = link, stack empty, ras_valid = 0; a further pop leaves the stack empty.
REQ-024 op=00, br_taken=1, tgt=0x1FE -> pc = TRAP_PC, misalign = 1, flush = 1, wb_valid = 0.
REQ-025 RAS_DEPTH+1 calls with links 0x4, 0x8, ... -> ras_top = last link; RAS_DEPTH pops return newest first; the 0x4 entry is lost.
REQ-026 pc = 0x1FC (PC_W=9), no redirect -> pc = 0x000; op=01, ex_pc=0x10, imm=0x1000 -> wb_data = 0x1010, pc unaffected.
